mmu_loader: RTL

- Upstream stage of mmu_feeder.
- Accepts a host byte stream into two 4-entry banks: weights and inputs.
- Sequences one matrix-multiply pass by driving en, mmu_cycle and output_sel to the feeder.
- Weights persist across passes, so a new input tile can reuse loaded weights without reloading.

---
 rtl/mmu_loader_pkg.sv | 16 +
 rtl/mmu_loader_bank4.sv | 55 +++++
 rtl/mmu_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/mmu_loader_pkg.sv
// Shared constants and state encoding for the MMU loader/feeder pair.
// The feeder reads LAST_CYCLE/OUT_FIRST from here too, so out_valid and done always agree.
package mmu_loader_pkg;
    localparam int DATA_W     = 8;
    localparam int N_ELEMS    = 4;
    localparam int PTR_W      = 2;
    localparam int LAST_CYCLE = 5;
    localparam int OUT_FIRST  = 2;
    localparam int CYC_W      = 3;
    localparam int SEL_W      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/mmu_loader_bank4.sv
// 4-entry byte register file with wrapping write pointer and a "full" flag.
// Writing slot 0 starts a fresh set (flag clears); writing the last slot marks it complete.
module mmu_bank4
    import mmu_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic              full
);
    logic [N_ELEMS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic                           full_q, full_d;

    always_comb begin
        mem_d  = mem_q;
        ptr_d  = ptr_q;
        full_d = full_q;
        if (clr) begin
            ptr_d  = '0;
            full_d = 1'b0;
        end else if (wr_en) begin
            mem_d[ptr_q] = wr_data;
            ptr_d        = ptr_q + 1'b1;
            if (ptr_q == '0)
                full_d = 1'b0;
            if (ptr_q == PTR_W'(N_ELEMS - 1))
                full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            ptr_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            ptr_q  <= ptr_d;
            full_q <= full_d;
        end
    end

    assign data0 = mem_q[0];
    assign data1 = mem_q[1];
    assign data2 = mem_q[2];
    assign data3 = mem_q[3];
    assign full  = full_q;
endmodule

// File: rtl/mmu_loader.sv
// Loads weight/input banks from a host byte stream and sequences one MMU pass.
// Weights survive a pass; only the input bank is re-armed when the pass ends.
module mmu_loader
    import mmu_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic              load_weight,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [DATA_W-1:0] weight0,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic [DATA_W-1:0] input0,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [DATA_W-1:0] input3,
    output logic              en,
    output logic [CYC_W-1:0]  mmu_cycle,
    output logic [SEL_W-1:0]  output_sel,
    output logic              out_valid,
    output logic              weights_loaded
);
    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             ov_q, ov_d;
    logic             inputs_full;
    logic             accept, w_wr, i_wr, pass_done;

    assign load_ready = (state_q == IDLE);
    assign accept     = load_valid && load_ready;
    assign w_wr       = accept && load_weight;
    // A complete input tile is held until its pass consumes it.
    assign i_wr       = accept && !load_weight && !inputs_full;
    assign pass_done  = (state_q == RUN) && (cyc_q == CYC_W'(LAST_CYCLE));

    mmu_bank4 u_wbank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_data (load_data),
        .clr     (1'b0),
        .data0   (weight0),
        .data1   (weight1),
        .data2   (weight2),
        .data3   (weight3),
        .full    (weights_loaded)
    );

    mmu_bank4 u_ibank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (i_wr),
        .wr_data (load_data),
        .clr     (pass_done),
        .data0   (input0),
        .data1   (input1),
        .data2   (input2),
        .data3   (input3),
        .full    (inputs_full)
    );

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: begin
                if (weights_loaded && inputs_full) begin
                    state_d = RUN;
                    en_d    = 1'b1;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                if (pass_done) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Readout window is registered alongside mmu_cycle so both move on the same edge.
        ov_d  = en_d && (cyc_d >= CYC_W'(OUT_FIRST)) && (cyc_d <= CYC_W'(LAST_CYCLE));
        sel_d = ov_d ? SEL_W'(cyc_d - CYC_W'(OUT_FIRST)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            cyc_q   <= '0;
            sel_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cyc_q   <= cyc_d;
            sel_q   <= sel_d;
            ov_q    <= ov_d;
        end
    end

    assign en         = en_q;
    assign mmu_cycle  = cyc_q;
    assign output_sel = sel_q;
    assign out_valid  = ov_q;
endmodule
